// File: rtl/game_flow_control.sv
// Game flow sequencer: welcome screen, play, game-over/win end screens,
// flipper selection, high-score tracking and per-state pixel selection.
module game_flow_control #(
    parameter logic [15:0] WIN_SCORE        = 16'd999,
    parameter int          OVER_HOLD_FRAMES = 120,
    parameter int          SETTLE_FRAMES    = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        key5IsPressed,
    input  logic        key3IsPressed,
    input  logic [3:0]  life,
    input  logic [15:0] score,
    input  logic [7:0]  RGB_screen_start,
    input  logic [7:0]  RGB_screen_main,
    input  logic [7:0]  RGB_screen_end,
    output logic        start,
    output logic        flipperType,
    output logic [1:0]  screenState,
    output logic [15:0] highScore,
    output logic [7:0]  RGB_out
);

    localparam int MAX_FRAMES = (OVER_HOLD_FRAMES > SETTLE_FRAMES) ? OVER_HOLD_FRAMES : SETTLE_FRAMES;
    localparam int CNT_W      = (MAX_FRAMES < 1) ? 1 : $clog2(MAX_FRAMES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(OVER_HOLD_FRAMES);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_FRAMES);

    typedef enum logic [1:0] {
        START     = 2'd0,
        PLAYING   = 2'd1,
        GAME_OVER = 2'd2,
        WIN       = 2'd3
    } gameStateT;

    gameStateT        state;
    logic [CNT_W-1:0] frameCnt;
    logic             key5Prev;
    logic             key3Prev;
    logic             key5Armed;
    logic             key3Armed;
    logic             key5Press;
    logic             key3Press;

    // A key only becomes armed once it has been seen released after reset,
    // so a key held through reset release cannot trigger a press.
    assign key5Press   = key5IsPressed & ~key5Prev & key5Armed;
    assign key3Press   = key3IsPressed & ~key3Prev & key3Armed;
    assign screenState = state;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= START;
            start       <= 1'b0;
            flipperType <= 1'b0;
            highScore   <= 16'd0;
            RGB_out     <= 8'd0;
            frameCnt    <= '0;
            key5Prev    <= 1'b0;
            key3Prev    <= 1'b0;
            key5Armed   <= 1'b0;
            key3Armed   <= 1'b0;
        end else begin
            key5Prev  <= key5IsPressed;
            key3Prev  <= key3IsPressed;
            key5Armed <= key5Armed | ~key5IsPressed;
            key3Armed <= key3Armed | ~key3IsPressed;
            start     <= 1'b0;

            case (state)
                START:   RGB_out <= RGB_screen_start;
                PLAYING: RGB_out <= RGB_screen_main;
                default: RGB_out <= RGB_screen_end;
            endcase

            case (state)
                START: begin
                    if (key3Press)
                        flipperType <= ~flipperType;
                    if (key5Press) begin
                        start    <= 1'b1;
                        state    <= PLAYING;
                        frameCnt <= '0;
                    end
                end
                // Winning is checked first so it beats a simultaneous loss.
                PLAYING: begin
                    if (score >= WIN_SCORE) begin
                        state    <= WIN;
                        frameCnt <= '0;
                        if (score > highScore)
                            highScore <= score;
                    end else if (life == 4'd0 && frameCnt == SETTLE_MAX) begin
                        state    <= GAME_OVER;
                        frameCnt <= '0;
                        if (score > highScore)
                            highScore <= score;
                    end else if (startOfFrame && frameCnt < SETTLE_MAX) begin
                        frameCnt <= frameCnt + CNT_W'(1);
                    end
                end
                GAME_OVER, WIN: begin
                    if (key5Press && frameCnt == HOLD_MAX)
                        state <= START;
                    else if (startOfFrame && frameCnt < HOLD_MAX)
                        frameCnt <= frameCnt + CNT_W'(1);
                end
                default: state <= START;
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_control.sv
// Self-checking bench for game_flow_control: directed scenarios plus a
// randomized run compared against a behavioural model of the game rules.
module tb_game_flow_control;

    localparam int WIN    = 999;
    localparam int SETTLE = 2;
    localparam int HOLD   = 120;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        key5IsPressed = 1'b0;
    logic        key3IsPressed = 1'b0;
    logic [3:0]  life = 4'd3;
    logic [15:0] score = 16'd0;
    logic [7:0]  rgbStart = 8'h11;
    logic [7:0]  rgbMain = 8'h22;
    logic [7:0]  rgbEnd = 8'h33;
    logic        start;
    logic        flipperType;
    logic [1:0]  screenState;
    logic [15:0] highScore;
    logic [7:0]  RGB_out;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          mMode = 0;
    int          mFrames = 0;
    int          mHigh = 0;
    logic        mFlip = 1'b0;
    logic        mStart = 1'b0;
    logic [7:0]  mRgb = 8'd0;
    logic        mK5Prev = 1'b0;
    logic        mK3Prev = 1'b0;
    logic        mK5SeenLow = 1'b0;
    logic        mK3SeenLow = 1'b0;

    game_flow_control dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .key5IsPressed(key5IsPressed), .key3IsPressed(key3IsPressed),
        .life(life), .score(score),
        .RGB_screen_start(rgbStart), .RGB_screen_main(rgbMain), .RGB_screen_end(rgbEnd),
        .start(start), .flipperType(flipperType), .screenState(screenState),
        .highScore(highScore), .RGB_out(RGB_out)
    );

    always #5 clk = ~clk;

    function automatic void endGame(int mode);
        if (int'(score) > mHigh)
            mHigh = int'(score);
        mMode   = mode;
        mFrames = 0;
    endfunction

    // One clock of the game rules, using the inputs present at the edge.
    function automatic void modelStep();
        logic p5;
        logic p3;
        if (!resetN) begin
            mMode = 0; mFrames = 0; mHigh = 0; mFlip = 1'b0; mStart = 1'b0; mRgb = 8'd0;
            mK5Prev = 1'b0; mK3Prev = 1'b0; mK5SeenLow = 1'b0; mK3SeenLow = 1'b0;
            return;
        end
        p5 = key5IsPressed && !mK5Prev && mK5SeenLow;
        p3 = key3IsPressed && !mK3Prev && mK3SeenLow;
        mK5Prev = key5IsPressed;
        mK3Prev = key3IsPressed;
        mK5SeenLow = mK5SeenLow || !key5IsPressed;
        mK3SeenLow = mK3SeenLow || !key3IsPressed;
        mStart = 1'b0;
        mRgb = (mMode == 0) ? rgbStart : (mMode == 1) ? rgbMain : rgbEnd;
        if (mMode == 0) begin
            if (p3) mFlip = !mFlip;
            if (p5) begin mStart = 1'b1; mMode = 1; mFrames = 0; end
        end else if (mMode == 1) begin
            if (int'(score) >= WIN) endGame(3);
            else if (life == 4'd0 && mFrames == SETTLE) endGame(2);
            else if (startOfFrame && mFrames < SETTLE) mFrames = mFrames + 1;
        end else begin
            if (p5 && mFrames == HOLD) mMode = 0;
            else if (startOfFrame && mFrames < HOLD) mFrames = mFrames + 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic sofPulses(int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1; tick();
            startOfFrame = 1'b0; tick();
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0; tick(); tick();
        resetN = 1'b1; tick(); tick();
        checks++; if (screenState !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", screenState); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start: got %b expected 0", start); end
        checks++; if (flipperType !== 1'b0) begin errors++; $display("[TB] FAIL reset_flipper: got %b expected 0", flipperType); end
        checks++; if (highScore !== 16'd0) begin errors++; $display("[TB] FAIL reset_high: got %0d expected 0", highScore); end
    endtask

    task automatic test_flipper_select();
        life = 4'd3; score = 16'd0;
        for (int i = 0; i < 3; i++) begin
            key3IsPressed = 1'b1; tick();
            key3IsPressed = 1'b0; tick();
        end
        checks++; if (flipperType !== 1'b1) begin errors++; $display("[TB] FAIL flipper_x3: got %b expected 1", flipperType); end
        key5IsPressed = 1'b1; tick();
        checks++; if (start !== 1'b1) begin errors++; $display("[TB] FAIL start_pulse: got %b expected 1", start); end
        checks++; if (screenState !== 2'd1) begin errors++; $display("[TB] FAIL enter_play: got %0d expected 1", screenState); end
        key5IsPressed = 1'b0; tick();
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL start_one_cycle: got %b expected 0", start); end
    endtask

    task automatic test_settle_game_over();
        life = 4'd0; score = 16'd123;
        repeat (3) tick();
        checks++; if (screenState !== 2'd1) begin errors++; $display("[TB] FAIL settle_hold0: got %0d expected 1", screenState); end
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        checks++; if (screenState !== 2'd1) begin errors++; $display("[TB] FAIL settle_hold1: got %0d expected 1", screenState); end
        tick(); startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        checks++; if (screenState !== 2'd1) begin errors++; $display("[TB] FAIL settle_hold2: got %0d expected 1", screenState); end
        tick();
        checks++; if (screenState !== 2'd2) begin errors++; $display("[TB] FAIL game_over: got %0d expected 2", screenState); end
        checks++; if (highScore !== 16'd123) begin errors++; $display("[TB] FAIL high_first: got %0d expected 123", highScore); end
    endtask

    task automatic test_over_hold();
        tick();
        checks++; if (RGB_out !== 8'h33) begin errors++; $display("[TB] FAIL rgb_end: got %0h expected 33", RGB_out); end
        sofPulses(50);
        key5IsPressed = 1'b1; tick(); key5IsPressed = 1'b0;
        checks++; if (screenState !== 2'd2) begin errors++; $display("[TB] FAIL hold_frame50: got %0d expected 2", screenState); end
        tick(); sofPulses(69);
        key5IsPressed = 1'b1; tick(); key5IsPressed = 1'b0;
        checks++; if (screenState !== 2'd2) begin errors++; $display("[TB] FAIL hold_frame119: got %0d expected 2", screenState); end
        tick(); sofPulses(3);
        key5IsPressed = 1'b1; tick(); key5IsPressed = 1'b0;
        checks++; if (screenState !== 2'd0) begin errors++; $display("[TB] FAIL hold_release: got %0d expected 0", screenState); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL no_start_on_return: got %b expected 0", start); end
        tick();
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL no_start_after_return: got %b expected 0", start); end
    endtask

    task automatic test_win_priority();
        life = 4'd1; score = 16'd0;
        key5IsPressed = 1'b1; tick(); key5IsPressed = 1'b0; tick();
        sofPulses(2);
        life = 4'd0; score = 16'd999; tick();
        checks++; if (screenState !== 2'd3) begin errors++; $display("[TB] FAIL win_priority: got %0d expected 3", screenState); end
        checks++; if (highScore !== 16'd999) begin errors++; $display("[TB] FAIL high_win: got %0d expected 999", highScore); end
        sofPulses(120);
        key5IsPressed = 1'b1; tick(); key5IsPressed = 1'b0; tick();
        checks++; if (screenState !== 2'd0) begin errors++; $display("[TB] FAIL win_return: got %0d expected 0", screenState); end
    endtask

    task automatic test_rgb_midreset();
        life = 4'd3; score = 16'd0;
        checks++; if (RGB_out !== 8'h11) begin errors++; $display("[TB] FAIL rgb_start: got %0h expected 11", RGB_out); end
        key5IsPressed = 1'b1; tick(); key5IsPressed = 1'b0;
        checks++; if (RGB_out !== 8'h11) begin errors++; $display("[TB] FAIL rgb_latency: got %0h expected 11", RGB_out); end
        tick();
        checks++; if (RGB_out !== 8'h22) begin errors++; $display("[TB] FAIL rgb_main: got %0h expected 22", RGB_out); end
        resetN = 1'b0; tick();
        checks++; if (RGB_out !== 8'h00) begin errors++; $display("[TB] FAIL rgb_reset: got %0h expected 0", RGB_out); end
        checks++; if (screenState !== 2'd0) begin errors++; $display("[TB] FAIL midreset_state: got %0d expected 0", screenState); end
        checks++; if (highScore !== 16'd0) begin errors++; $display("[TB] FAIL midreset_high: got %0d expected 0", highScore); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL midreset_start: got %b expected 0", start); end
        resetN = 1'b1; tick(); tick();
    endtask

    task automatic test_high_score();
        key3IsPressed = 1'b1; tick(); key3IsPressed = 1'b0; tick();
        for (int g = 0; g < 2; g++) begin
            life = 4'd3; score = (g == 0) ? 16'd300 : 16'd200;
            key5IsPressed = 1'b1; tick(); key5IsPressed = 1'b0; tick();
            key3IsPressed = 1'b1; tick(); key3IsPressed = 1'b0; tick();
            checks++; if (flipperType !== 1'b1) begin errors++; $display("[TB] FAIL flipper_locked: got %b expected 1", flipperType); end
            life = 4'd0; sofPulses(2);
            checks++; if (screenState !== 2'd2) begin errors++; $display("[TB] FAIL game%0d_over: got %0d expected 2", g, screenState); end
            checks++; if (highScore !== 16'd300) begin errors++; $display("[TB] FAIL game%0d_high: got %0d expected 300", g, highScore); end
            sofPulses(120);
            key5IsPressed = 1'b1; tick(); key5IsPressed = 1'b0; tick();
        end
    endtask

    task automatic test_held_key_reset();
        key5IsPressed = 1'b1; resetN = 1'b0; tick(); tick();
        resetN = 1'b1; tick(); tick(); tick();
        checks++; if (screenState !== 2'd0) begin errors++; $display("[TB] FAIL held_key_state: got %0d expected 0", screenState); end
        checks++; if (start !== 1'b0) begin errors++; $display("[TB] FAIL held_key_start: got %b expected 0", start); end
        key5IsPressed = 1'b0; tick();
        key5IsPressed = 1'b1; tick();
        checks++; if (screenState !== 2'd1) begin errors++; $display("[TB] FAIL repress_state: got %0d expected 1", screenState); end
        checks++; if (start !== 1'b1) begin errors++; $display("[TB] FAIL repress_start: got %b expected 1", start); end
        key5IsPressed = 1'b0; tick();
    endtask

    task automatic test_random();
        logic prevStart;
        prevStart = start;
        for (int i = 0; i < 4000; i++) begin
            resetN        = ($urandom_range(0, 599) != 0);
            startOfFrame  = ($urandom_range(0, 3) == 0);
            key5IsPressed = ($urandom_range(0, 3) == 0);
            key3IsPressed = ($urandom_range(0, 2) == 0);
            life          = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 15) == 0)
                score = ($urandom_range(0, 40) == 0) ? 16'($urandom_range(999, 65535)) : 16'($urandom_range(0, 998));
            rgbStart = 8'($urandom); rgbMain = 8'($urandom); rgbEnd = 8'($urandom);
            tick();
            checks++; if (screenState !== 2'(mMode)) begin errors++; $display("[TB] FAIL rnd_state @%0d: got %0d expected %0d", i, screenState, mMode); end
            checks++; if (start !== mStart) begin errors++; $display("[TB] FAIL rnd_start @%0d: got %b expected %b", i, start, mStart); end
            checks++; if (flipperType !== mFlip) begin errors++; $display("[TB] FAIL rnd_flipper @%0d: got %b expected %b", i, flipperType, mFlip); end
            checks++; if (highScore !== 16'(mHigh)) begin errors++; $display("[TB] FAIL rnd_high @%0d: got %0d expected %0d", i, highScore, mHigh); end
            checks++; if (RGB_out !== mRgb) begin errors++; $display("[TB] FAIL rnd_rgb @%0d: got %0h expected %0h", i, RGB_out, mRgb); end
            checks++; if (start === 1'b1 && prevStart === 1'b1) begin errors++; $display("[TB] FAIL rnd_start_twice @%0d: got 1 expected 0", i); end
            prevStart = start;
        end
        resetN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_flipper_select();
        test_settle_game_over();
        test_over_hold();
        test_win_priority();
        test_rgb_midreset();
        test_high_score();
        test_held_key_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
